// File: rtl/pixel_proc_pipe.sv
// Two-stage RGB pixel processor (pass / gray / invert / binary) on a valid-ready stream.
// Mode and threshold are latched on start-of-frame pixels and travel with each pixel.
module pixel_proc_pipe #(
  parameter int CW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      mode_in,
  input  logic [CW-1:0]   thresh_in,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic            s_sof,
  input  logic [3*CW-1:0] s_rgb,
  output logic            m_valid,
  input  logic            m_ready,
  output logic            m_sof,
  output logic [3*CW-1:0] m_rgb
);

  localparam int AW = CW + 9;

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_GRAY = 2'd1,
    MODE_INV  = 2'd2,
    MODE_BIN  = 2'd3
  } mode_e;

  mode_e            active_mode_q;
  logic [CW-1:0]    active_thresh_q;

  logic             s1_valid_q;
  logic             s1_sof_q;
  mode_e            s1_mode_q;
  logic [CW-1:0]    s1_thresh_q;
  logic [CW-1:0]    s1_r_q;
  logic [CW-1:0]    s1_g_q;
  logic [CW-1:0]    s1_b_q;
  logic [CW-1:0]    s1_y_q;

  logic             m_valid_q;
  logic             m_sof_q;
  logic [3*CW-1:0]  m_rgb_q;

  logic             advance;
  logic             accept;
  logic [CW-1:0]    in_r;
  logic [CW-1:0]    in_g;
  logic [CW-1:0]    in_b;
  mode_e            pix_mode_d;
  logic [CW-1:0]    pix_thresh_d;
  logic [AW-1:0]    luma_acc;
  logic [CW-1:0]    luma_d;
  logic [3*CW-1:0]  m_rgb_d;

  assign advance = m_ready || !m_valid_q;
  assign s_ready = advance;
  assign accept  = s_valid && advance;

  assign {in_r, in_g, in_b} = s_rgb;

  // An sof pixel uses the freshly requested settings, not the latched ones.
  assign pix_mode_d   = s_sof ? mode_e'(mode_in) : active_mode_q;
  assign pix_thresh_d = s_sof ? thresh_in : active_thresh_q;

  assign luma_acc = AW'(77) * AW'(in_r) + AW'(150) * AW'(in_g)
                  + AW'(29) * AW'(in_b) + AW'(128);
  assign luma_d   = CW'(luma_acc >> 8);

  always_comb begin
    m_rgb_d = {s1_r_q, s1_g_q, s1_b_q};
    case (s1_mode_q)
      MODE_PASS: m_rgb_d = {s1_r_q, s1_g_q, s1_b_q};
      MODE_GRAY: m_rgb_d = {3{s1_y_q}};
      MODE_INV:  m_rgb_d = ~{s1_r_q, s1_g_q, s1_b_q};
      MODE_BIN:  m_rgb_d = (s1_y_q >= s1_thresh_q) ? '1 : '0;
      default:   m_rgb_d = {s1_r_q, s1_g_q, s1_b_q};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_mode_q   <= MODE_PASS;
      active_thresh_q <= '0;
      s1_valid_q      <= 1'b0;
      s1_sof_q        <= 1'b0;
      s1_mode_q       <= MODE_PASS;
      s1_thresh_q     <= '0;
      s1_r_q          <= '0;
      s1_g_q          <= '0;
      s1_b_q          <= '0;
      s1_y_q          <= '0;
      m_valid_q       <= 1'b0;
      m_sof_q         <= 1'b0;
      m_rgb_q         <= '0;
    end else begin
      if (accept && s_sof) begin
        active_mode_q   <= mode_e'(mode_in);
        active_thresh_q <= thresh_in;
      end
      if (advance) begin
        s1_valid_q  <= s_valid;
        s1_sof_q    <= s_valid && s_sof;
        s1_mode_q   <= pix_mode_d;
        s1_thresh_q <= pix_thresh_d;
        s1_r_q      <= in_r;
        s1_g_q      <= in_g;
        s1_b_q      <= in_b;
        s1_y_q      <= luma_d;
        m_valid_q   <= s1_valid_q;
        m_sof_q     <= s1_valid_q && s1_sof_q;
        m_rgb_q     <= m_rgb_d;
      end
    end
  end

  assign m_valid = m_valid_q;
  assign m_sof   = m_sof_q;
  assign m_rgb   = m_rgb_q;

endmodule

// File: tb/tb_pixel_proc_pipe.sv
// Directed and stalled-stream bench for pixel_proc_pipe at CW=4.
module tb_pixel_proc_pipe;

  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      mode_in;
  logic [CW-1:0]   thresh_in;
  logic            s_valid;
  logic            s_ready;
  logic            s_sof;
  logic [3*CW-1:0] s_rgb;
  logic            m_valid;
  logic            m_ready;
  logic            m_sof;
  logic [3*CW-1:0] m_rgb;

  int n_chk  = 0;
  int n_fail = 0;
  int edge_cnt = 0;
  int n_out = 0;
  int rdy_mode = 0;
  logic lat_on = 1'b1;

  logic [11:0] exp_q[$];
  logic        sof_q[$];
  int          acc_q[$];

  logic        stall_prev = 1'b0;
  logic [11:0] held_rgb;
  logic        held_sof;
  logic [11:0] mon_e;
  logic        mon_s;
  int          mon_a;

  pixel_proc_pipe #(.CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode_in   (mode_in),
    .thresh_in (thresh_in),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_sof     (s_sof),
    .s_rgb     (s_rgb),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_sof     (m_sof),
    .m_rgb     (m_rgb)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt++;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = 1'b0;
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] gray(input logic [11:0] p);
    int y;
    y = (77 * int'(p[11:8]) + 150 * int'(p[7:4]) + 29 * int'(p[3:0]) + 128) >> 8;
    return {3{y[3:0]}};
  endfunction

  // Output monitor: sampled mid-cycle, one pop per output transfer.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", 32'(m_valid), 32'd1);
        check("stall_rgb", 32'(m_rgb), 32'(held_rgb));
        check("stall_sof", 32'(m_sof), 32'(held_sof));
      end
      if (m_valid && m_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          check("spurious_out", 32'(m_rgb) | 32'h1000, 32'h0);
        end else begin
          mon_e = exp_q.pop_front();
          mon_s = sof_q.pop_front();
          mon_a = acc_q.pop_front();
          check("out_rgb", 32'(m_rgb), 32'(mon_e));
          check("out_sof", 32'(m_sof), 32'(mon_s));
          if (lat_on) check("latency", 32'(edge_cnt - mon_a), 32'd2);
        end
      end
      stall_prev = m_valid && !m_ready;
      held_rgb   = m_rgb;
      held_sof   = m_sof;
    end
  end

  // Called just after a rising edge; returns just after the edge that took the pixel.
  task automatic send(input logic [11:0] rgb, input logic sof, input logic [1:0] md,
                      input logic [3:0] th, input logic [11:0] exp);
    int n = 0;
    s_valid = 1'b1;
    s_rgb = rgb;
    s_sof = sof;
    mode_in = md;
    thresh_in = th;
    @(negedge clk);
    while (!s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      check("accept_timeout", 32'(s_ready), 32'd1);
    end else begin
      exp_q.push_back(exp);
      sof_q.push_back(sof);
      acc_q.push_back(edge_cnt);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_sof = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [11:0] px;
    int out_base;
    rst = 1'b1;
    s_valid = 1'b0;
    s_sof = 1'b0;
    s_rgb = '0;
    mode_in = 2'd0;
    thresh_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_rgb", 32'(m_rgb), 32'd0);
    check("rst_m_sof", 32'(m_sof), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rdy_after_rst", 32'(s_ready), 32'd1);
    @(posedge clk);
    #1;

    // no sof yet: requested gray must be ignored, pixels pass through
    send(12'h8C4, 1'b0, 2'd1, 4'd0, 12'h8C4);
    send(12'hF00, 1'b0, 2'd1, 4'd0, 12'hF00);
    send(12'h00F, 1'b0, 2'd1, 4'd0, 12'h00F);

    send(12'hF00, 1'b1, 2'd1, 4'd0, 12'h555);
    send(12'h0F0, 1'b0, 2'd1, 4'd0, 12'h999);
    send(12'h00F, 1'b0, 2'd1, 4'd0, 12'h222);
    send(12'hFFF, 1'b0, 2'd1, 4'd0, 12'hFFF);
    send(12'h8C4, 1'b0, 2'd1, 4'd0, 12'hAAA);
    @(posedge clk);
    #1;

    send(12'h8C4, 1'b1, 2'd2, 4'd0,  12'h73B);
    send(12'h8C4, 1'b1, 2'd3, 4'd8,  12'hFFF);
    send(12'h00F, 1'b0, 2'd3, 4'd8,  12'h000);
    send(12'h8C4, 1'b1, 2'd3, 4'd10, 12'hFFF);
    send(12'h8C4, 1'b1, 2'd3, 4'd11, 12'h000);

    // mid-frame mode change waits for the next sof
    send(12'h0F0, 1'b1, 2'd1, 4'd0, 12'h999);
    send(12'hF00, 1'b0, 2'd2, 4'd0, 12'h555);
    send(12'h00F, 1'b0, 2'd2, 4'd0, 12'h222);
    send(12'h8C4, 1'b1, 2'd2, 4'd0, 12'h73B);
    send(12'hF00, 1'b0, 2'd2, 4'd0, 12'h0FF);
    send(12'h000, 1'b0, 2'd1, 4'd0, 12'hFFF);
    drain();

    // random stream in gray mode under random back-pressure
    lat_on = 1'b0;
    rdy_mode = 2;
    out_base = n_out;
    for (int i = 0; i < 1000; i++) begin
      px = 12'($urandom_range(0, 4095));
      send(px, (i == 0), (i == 0) ? 2'd1 : 2'($urandom_range(0, 3)),
           4'($urandom_range(0, 15)), gray(px));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    drain();
    check("stream_count", 32'(n_out - out_base), 32'd1000);

    // reset with two pixels held in the pipe
    rdy_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    send(12'hA5A, 1'b0, 2'd0, 4'd0, gray(12'hA5A));
    send(12'h3C3, 1'b0, 2'd0, 4'd0, gray(12'h3C3));
    check("inflight_valid", 32'(m_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_m_valid", 32'(m_valid), 32'd0);
    check("midrst_m_rgb", 32'(m_rgb), 32'd0);
    exp_q.delete();
    sof_q.delete();
    acc_q.delete();
    rst = 1'b0;
    rdy_mode = 0;
    lat_on = 1'b1;
    @(negedge clk);
    check("rdy_after_midrst", 32'(s_ready), 32'd1);
    @(posedge clk);
    #1;
    send(12'h8C4, 1'b0, 2'd1, 4'd0, 12'h8C4);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
